// File: rtl/disp_pkg.sv
// disp_pkg: shared constants, hex segment table and digit-skip helpers
// for display_scan_ctrl.
package disp_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  typedef struct packed {
    logic [2:0] idx;
    logic       wrap;
  } next_t;
  function automatic logic [2:0] first_enabled(input logic [7:0] mask);
    first_enabled = '0;
    for (int i = 7; i >= 0; i--) if (mask[i]) first_enabled = 3'(i);
  endfunction
  // Lowest enabled index above cur; otherwise wrap to the lowest enabled one
  // (an empty mask holds cur and still reports a wrap).
  function automatic next_t next_enabled(input logic [7:0] mask, input logic [2:0] cur);
    next_enabled.idx  = |mask ? first_enabled(mask) : cur;
    next_enabled.wrap = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i] && 3'(i) > cur) begin
        next_enabled.idx  = 3'(i);
        next_enabled.wrap = 1'b0;
      end
    end
  endfunction
endpackage

// File: rtl/hex_to_7seg.sv
// hex_to_7seg: combinational nibble to active-low {g,f,e,d,c,b,a} decoder.
module hex_to_7seg
  import disp_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg_n
);
  assign o_seg_n = SEG_LUT[i_nib];
endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexed 7-segment scanner with dwell/blank timing,
// digit mask, leading-zero suppression and frame-coherent input capture.
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 10,
  parameter int BLANK_CYCLES = 1,
  parameter int PTR_W        = $clog2(NUM_DIGITS)
) (
  input  logic                    clk_10kHz,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] hex_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_blank,
  output logic [PTR_W-1:0]        digit,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic                    frame_tick
);
  localparam int CNT_W = $clog2(DWELL_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLK  = CNT_W'(BLANK_CYCLES);

  // Frame registers are kept 8 lanes wide so the 3-bit pointer indexes them exactly.
  logic [2:0]            r_digit;
  logic [CNT_W-1:0]      r_dwell;
  logic [31:0]           r_hex;
  logic [7:0]            r_dp;
  logic [7:0]            r_en;
  logic                  r_lz;
  logic [NUM_DIGITS-1:0] r_an;
  logic [6:0]            r_seg;
  logic                  r_dp_n;
  next_t                 w_nxt;
  logic                  w_end;
  logic                  w_wrap;
  logic                  w_blank;
  logic                  w_show;
  logic                  w_lz_hide;
  logic [7:0]            w_lz;
  logic [3:0]            w_nib;
  logic [6:0]            w_seg;

  always_comb begin
    w_nxt     = next_enabled(r_en, r_digit);
    w_end     = r_dwell == LAST;
    w_wrap    = w_end && w_nxt.wrap;
    w_blank   = r_dwell < BLK;
    w_show    = r_en[r_digit];
    w_nib     = r_hex[{r_digit, 2'b00} +: 4];
    for (int i = 0; i < 8; i++) w_lz[i] = ~|(r_hex >> (4 * i));
    w_lz_hide = r_lz && |r_digit && w_lz[r_digit];
  end

  hex_to_7seg u_dec (
    .i_nib  (w_nib),
    .o_seg_n(w_seg)
  );

  always_ff @(posedge clk_10kHz or negedge rst_n) begin
    if (!rst_n) begin
      r_digit <= '0;
      r_dwell <= '0;
      r_hex   <= '0;
      r_dp    <= '0;
      r_en    <= '0;
      r_lz    <= 1'b0;
      r_an    <= '1;
      r_seg   <= SEG_BLANK;
      r_dp_n  <= 1'b1;
    end else begin
      r_dwell <= w_end ? '0 : r_dwell + 1'b1;
      if (w_wrap) begin
        r_hex   <= 32'(hex_in);
        r_dp    <= 8'(dp_in);
        r_en    <= 8'(digit_en);
        r_lz    <= lz_blank;
        r_digit <= |digit_en ? first_enabled(8'(digit_en)) : r_digit;
      end else if (w_end) begin
        r_digit <= w_nxt.idx;
      end
      r_an   <= w_blank ? '1 : ~(NUM_DIGITS'(w_show) << r_digit);
      r_seg  <= (w_blank || !w_show || w_lz_hide) ? SEG_BLANK : w_seg;
      r_dp_n <= w_blank || !(w_show && r_dp[r_digit]);
    end
  end

  assign digit      = r_digit[PTR_W-1:0];
  assign an_n       = r_an;
  assign seg_n      = r_seg;
  assign dp_n       = r_dp_n;
  assign frame_tick = w_wrap;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: scoreboard bench; stimulus queues expected lit-digit
// events and frame_tick intervals, a negedge monitor pops and compares them.
module tb_display_scan_ctrl;
  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } ev_t;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b1;
  logic [15:0] hex_in   = '0;
  logic [3:0]  dp_in    = '0;
  logic [3:0]  digit_en = '0;
  logic        lz_blank = 1'b0;
  logic [1:0]  digit;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic        frame_tick;

  ev_t        evq[$];
  int         tkq[$];
  int         checks    = 0;
  int         errors    = 0;
  int         cyc       = 0;
  int         run_len   = 0;
  int         last_tick = 0;
  int         tk_exp;
  ev_t        ev_exp;
  logic [3:0] prev_an   = 4'hF;
  logic [6:0] s_1234 [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
  logic [6:0] s_0050 [4] = '{7'h40, 7'h12, 7'h7F, 7'h7F};

  display_scan_ctrl #(
    .NUM_DIGITS  (4),
    .DWELL_CYCLES(4),
    .BLANK_CYCLES(1)
  ) dut (
    .clk_10kHz (clk),
    .rst_n     (rst_n),
    .hex_in    (hex_in),
    .dp_in     (dp_in),
    .digit_en  (digit_en),
    .lz_blank  (lz_blank),
    .digit     (digit),
    .an_n      (an_n),
    .seg_n     (seg_n),
    .dp_n      (dp_n),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) cyc <= rst_n ? cyc + 1 : 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_an   = 4'hF;
      run_len   = 0;
      last_tick = 0;
    end else begin
      checks++;
      if ($countones(~an_n) > 1) begin
        errors++;
        $display("FAIL onehot an_n=%b want at most one low bit", an_n);
      end
      if (an_n != 4'hF && an_n != prev_an) begin
        checks++;
        if (evq.size() == 0) begin
          errors++;
          $display("FAIL event_unexpected got an_n=%b seg_n=%h dp_n=%b want none", an_n, seg_n, dp_n);
        end else begin
          ev_exp = evq.pop_front();
          if ({an_n, seg_n, dp_n} !== ev_exp) begin
            errors++;
            $display("FAIL event got an_n=%b seg_n=%h dp_n=%b want an_n=%b seg_n=%h dp_n=%b",
                     an_n, seg_n, dp_n, ev_exp.an, ev_exp.seg, ev_exp.dp);
          end
        end
      end
      if (prev_an != 4'hF && an_n != prev_an) begin
        checks++;
        if (run_len != 3) begin
          errors++;
          $display("FAIL lit_len got %0d want 3", run_len);
        end
      end
      run_len = (an_n == 4'hF) ? 0 : (an_n == prev_an ? run_len + 1 : 1);
      if (frame_tick) begin
        checks++;
        if (tkq.size() == 0) begin
          errors++;
          $display("FAIL tick_unexpected at cycle %0d want none", cyc);
        end else begin
          tk_exp = tkq.pop_front();
          if (cyc - last_tick != tk_exp) begin
            errors++;
            $display("FAIL tick_interval got %0d want %0d", cyc - last_tick, tk_exp);
          end
        end
        last_tick = cyc;
      end
      prev_an = an_n;
    end
  end

  function automatic logic [3:0] an_of(input int d);
    return ~(4'b0001 << d);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push_ev(input logic [3:0] an, input logic [6:0] seg, input logic dp);
    ev_t e;
    e.an  = an;
    e.seg = seg;
    e.dp  = dp;
    evq.push_back(e);
  endtask

  task automatic push_tk(input int n, input int interval);
    repeat (n) tkq.push_back(interval);
  endtask

  task automatic start(input logic [15:0] h, input logic [3:0] dp, input logic [3:0] en, input logic lz);
    @(negedge clk);
    rst_n    = 1'b0;
    hex_in   = h;
    dp_in    = dp;
    digit_en = en;
    lz_blank = lz;
    #1;
    chk("rst_an_n", 32'(an_n), 32'hF);
    chk("rst_seg_n", 32'(seg_n), 32'h7F);
    chk("rst_dp_n", 32'(dp_n), 32'h1);
    chk("rst_digit", 32'(digit), 32'h0);
    chk("rst_tick", 32'(frame_tick), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    checks++;
    if (evq.size() != 0 || tkq.size() != 0) begin
      errors++;
      $display("FAIL drain_%s got events=%0d ticks=%0d left want 0 0", name, evq.size(), tkq.size());
    end
    evq.delete();
    tkq.delete();
  endtask

  initial begin
    #1 rst_n = 1'b0;
    // full scan of 1234
    start(16'h1234, 4'h0, 4'hF, 1'b0);
    for (int k = 0; k < 9; k++) push_ev(an_of(k % 4), s_1234[k % 4], 1'b1);
    push_tk(1, 3);
    push_tk(2, 16);
    run(40);
    drain("scan");
    // mask 0101 skips digits 1 and 3, dp on digit 2
    start(16'h1234, 4'b0100, 4'b0101, 1'b0);
    for (int k = 0; k < 9; k++) push_ev(an_of((k % 2) * 2), s_1234[(k % 2) * 2], (k % 2) == 0);
    push_tk(1, 3);
    push_tk(4, 8);
    run(40);
    drain("mask");
    // leading zeros on 0050, dp still shown on blanked digit 3
    start(16'h0050, 4'b1000, 4'hF, 1'b1);
    for (int k = 0; k < 9; k++) push_ev(an_of(k % 4), s_0050[k % 4], (k % 4) != 3);
    push_tk(1, 3);
    push_tk(2, 16);
    run(40);
    drain("lz0050");
    // all-zero value keeps only digit 0 visible
    start(16'h0000, 4'h0, 4'hF, 1'b1);
    for (int k = 0; k < 4; k++) push_ev(an_of(k), k == 0 ? 7'h40 : 7'h7F, 1'b1);
    push_tk(1, 3);
    push_tk(1, 16);
    run(20);
    drain("lz0000");
    // mid-frame input change is held off until the next frame
    start(16'h1111, 4'h0, 4'hF, 1'b0);
    for (int k = 0; k < 8; k++) push_ev(an_of(k % 4), k < 4 ? 7'h79 : 7'h24, 1'b1);
    push_tk(1, 3);
    push_tk(2, 16);
    run(13);
    chk("tear_digit", 32'(digit), 32'h2);
    hex_in = 16'h2222;
    run(23);
    drain("tear");
    // empty mask stays dark, then digit 3 alone from the next frame
    start(16'h1234, 4'h0, 4'h0, 1'b0);
    for (int k = 0; k < 7; k++) push_ev(4'b0111, 7'h79, 1'b1);
    push_tk(1, 3);
    push_tk(9, 4);
    run(9);
    digit_en = 4'b1000;
    run(31);
    drain("empty");
    // asynchronous reset in the middle of digit 2's dwell
    start(16'h1234, 4'h0, 4'hF, 1'b0);
    push_ev(4'b1110, 7'h19, 1'b1);
    push_ev(4'b1101, 7'h30, 1'b1);
    push_tk(1, 3);
    run(13);
    chk("async_pre_digit", 32'(digit), 32'h2);
    rst_n = 1'b0;
    #1;
    chk("async_an_n", 32'(an_n), 32'hF);
    chk("async_seg_n", 32'(seg_n), 32'h7F);
    chk("async_dp_n", 32'(dp_n), 32'h1);
    chk("async_digit", 32'(digit), 32'h0);
    drain("async");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
